// File: rtl/sum_accumulator_if.sv
// Handshake bundle between a sum producer/frame controller and sum_accumulator.
// The master drives frame control, input beats and result acceptance; the slave is the accumulator.
interface sum_accumulator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  frame_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_sum;
  logic [LEN_WIDTH-1:0]  out_count;
  logic                  out_overflow;
  logic                  busy;

  modport master (
    output start, frame_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow, busy
  );

  modport slave (
    input  start, frame_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow, busy
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of unsigned sums into a saturating total and
// presents one per-frame result (sum, count, overflow) over a valid/ready handshake.
module sum_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_WIDTH  = 8
) (
  input logic                clock,
  input logic                rst_n,
  sum_accumulator_if.slave   acc_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [LEN_WIDTH-1:0]   count_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic                   ovf_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [ACC_WIDTH-1:0]   acc_d;
  logic                   ovf_hit_d;
  logic                   ovf_d;

  // Returns {saturated_flag, value}; the extra top bit catches the carry out of the accumulator.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic [ACC_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] wide;
    wide = {1'b0, a} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, b};
    if (wide[ACC_WIDTH]) begin
      sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
    end else begin
      sat_add = wide;
    end
  endfunction

  // Candidate accumulator value for the beat currently offered.
  always_comb begin
    {ovf_hit_d, acc_d} = sat_add(acc_q, acc_if.in_data);
    ovf_d              = ovf_q | ovf_hit_d;
  end

  // Frame control FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_WIDTH{1'b0}};
      count_q     <= {LEN_WIDTH{1'b0}};
      remaining_q <= {LEN_WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_if.start) begin
            acc_q   <= {ACC_WIDTH{1'b0}};
            count_q <= {LEN_WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (acc_if.frame_len != {LEN_WIDTH{1'b0}}) begin
              remaining_q <= acc_if.frame_len;
              state_q     <= ACCUM;
              in_ready_q  <= 1'b1;
            end else begin
              remaining_q <= {LEN_WIDTH{1'b0}};
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (acc_if.in_valid) begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_q + LEN_WIDTH'(1);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          // Result registers are left intact after acceptance; the next start clears them.
          if (acc_if.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_if.in_ready     = in_ready_q;
  assign acc_if.out_valid    = out_valid_q;
  assign acc_if.out_sum      = acc_q;
  assign acc_if.out_count    = count_q;
  assign acc_if.out_overflow = ovf_q;
  assign acc_if.busy         = busy_q;

endmodule
